// File: rtl/id_lookup_pkg.sv
// Shared ID-lookup constants and FSM state encoding.
// Used by the lookup engine and anything else that has to agree on ID/ROM geometry.
package id_lookup_pkg;

  localparam int ID_DIGITS = 10;
  localparam int DATA_W    = ID_DIGITS * 4;
  localparam int ADDR_W    = 4;
  localparam int N_ENTRIES = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/id_lookup_bcd_check.sv
// Combinational BCD validity check: valid=1 iff every nibble of in is 0..9.
// No latency; no flow control.
module bcd_check #(
  parameter int DATA_W = 40
) (
  input  logic [DATA_W-1:0] in,
  output logic              valid
);

  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < DATA_W / 4; i++) begin
      if (in[4*i +: 4] > 4'd9) valid = 1'b0;
    end
  end

endmodule

// File: rtl/id_lookup.sv
// Sequential search of the registered-ID ROM for a 10-digit BCD ID; reports match/index or a BCD error.
// Latency: 2k+2 cycles for a hit at index k, 2*N_ENTRIES for a miss, 1 for bad BCD; start ignored while busy.
module id_lookup
  import id_lookup_pkg::*;
#(
  parameter int N_ENTRIES_P = N_ENTRIES,
  parameter int ADDR_W_P    = ADDR_W,
  parameter int DATA_W_P    = DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W_P-1:0] id_in,
  output logic [ADDR_W_P-1:0] rom_addr,
  input  logic [DATA_W_P-1:0] rom_data,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic [ADDR_W_P-1:0] match_idx,
  output logic                bcd_err
);

  localparam logic [ADDR_W_P-1:0] LAST_ADDR = ADDR_W_P'(N_ENTRIES_P - 1);

  state_t              state;
  logic [DATA_W_P-1:0] id_q;
  logic                id_ok;

  bcd_check #(.DATA_W(DATA_W_P)) u_bcd_check (
    .in    (id_in),
    .valid (id_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      id_q      <= '0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      match_idx <= '0;
      bcd_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            id_q      <= id_in;
            match     <= 1'b0;
            match_idx <= '0;
            busy      <= 1'b1;
            if (!id_ok) begin
              bcd_err <= 1'b1;
              state   <= DONE;
            end else begin
              bcd_err  <= 1'b0;
              rom_addr <= '0;
              state    <= FETCH;
            end
          end
        end
        FETCH: state <= CMP;
        CMP: begin
          if (rom_data == id_q) begin
            match     <= 1'b1;
            match_idx <= rom_addr;
            done      <= 1'b1;
            state     <= DONE;
          end else if (rom_addr == LAST_ADDR) begin
            match <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            state    <= FETCH;
          end
        end
        DONE: begin
          // A search arrives with done already set; the BCD-error path arrives
          // with it clear and spends one cycle raising it.
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_id_lookup.sv
// Directed bench for id_lookup with a registered 5-entry ROM model.
module tb_id_lookup;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [39:0] id_in = '0;
  logic [39:0] rom_data;
  logic [3:0]  rom_addr;
  logic [3:0]  match_idx;
  logic        busy, done, match, bcd_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [3:0] max_addr = '0;

  logic [39:0] rom [0:4];
  initial begin
    rom[0] = 40'h1022440206;
    rom[1] = 40'h1015480227;
    rom[2] = 40'h1024869274;
    rom[3] = 40'h1026940483;
    rom[4] = 40'h1020833802;
  end

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= (rom_addr < 4'd5) ? rom[rom_addr] : 40'hFFFFFFFFFF;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rom_addr > max_addr) max_addr = rom_addr;
  end

  id_lookup dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .id_in     (id_in),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy),
    .done      (done),
    .match     (match),
    .match_idx (match_idx),
    .bcd_err   (bcd_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_search(input string tag, input logic [39:0] id, input int exp_edge,
                            input logic exp_match, input logic [3:0] exp_idx,
                            input logic exp_bcd, input int restart_edge);
    int n;
    logic [3:0] prev_addr;
    @(negedge clk);
    prev_addr = rom_addr;
    id_in = id;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Point id_in at a different ROM word to show the captured copy is used.
    id_in = (id == 40'h1015480227) ? 40'h1022440206 : 40'h1015480227;
    max_addr = '0;
    done_cnt = 0;
    n = 0;
    check({tag, "_busy_e0"}, busy, 1'b1);
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      #1;
      start = (n == restart_edge - 1);
    end
    start = 1'b0;
    check({tag, "_done_edge"}, n, exp_edge);
    check({tag, "_match"}, match, exp_match);
    check({tag, "_idx"}, match_idx, exp_idx);
    check({tag, "_bcd"}, bcd_err, exp_bcd);
    check({tag, "_busy_at_done"}, busy, 1'b1);
    if (exp_bcd) check({tag, "_addr_kept"}, rom_addr, prev_addr);
    else check({tag, "_max_addr"}, max_addr, exp_match ? exp_idx : 4'd4);
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, done, 1'b0);
    check({tag, "_busy_fall"}, busy, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_max_addr_bound"}, max_addr <= 4'd4, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_addr"}, rom_addr, 4'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_match"}, match, 1'b0);
    check({tag, "_idx"}, match_idx, 4'd0);
    check({tag, "_bcd"}, bcd_err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_search("t1_hit0",  40'h1022440206, 2,  1'b1, 4'd0, 1'b0, -1);
    run_search("t2_hit4",  40'h1020833802, 10, 1'b1, 4'd4, 1'b0, -1);
    run_search("t3_miss",  40'h1022440207, 10, 1'b0, 4'd0, 1'b0, -1);
    run_search("t4_bcd",   40'h10224402A6, 1,  1'b0, 4'd0, 1'b1, -1);
    run_search("t5_busy",  40'h1026940483, 8,  1'b1, 4'd3, 1'b0, 3);

    // Reset in the middle of a search: everything clears at once, no done.
    @(negedge clk);
    id_in = 40'h1020833802;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0;
    repeat (4) @(posedge clk);
    #3;
    check("t6_busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("t6_no_done", done_cnt, 0);
    run_search("t6_after", 40'h1015480227, 4, 1'b1, 4'd1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
